// File: rtl/name_decoder.sv
// name_decoder: streaming matcher for the fixed 14-character name "Mihir Mahajan ".
// One character is accepted per clk edge when valid is high. The only sequence
// state is pos (characters matched so far). q, match, err and hits are all
// registered views of that progress. After a mismatch the matcher can restart
// only on 'M'; it does not search for any other overlapping prefix.
module name_decoder (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  ascii,
  input  logic        valid,
  output logic [0:13] q,
  output logic [3:0]  pos,
  output logic        match,
  output logic        err,
  output logic [7:0]  hits
);

  localparam logic [6:0] RESTART_CH = 7'h4D;  // 'M', the first ROM character
  localparam logic [3:0] LAST_IDX   = 4'd13;

  // Name ROM, indexed by the number of characters already matched.
  function automatic logic [6:0] rom(input logic [3:0] i);
    logic [6:0] c;
    c = 7'h20;
    case (i)
      4'd0:    c = 7'h4D;
      4'd1:    c = 7'h69;
      4'd2:    c = 7'h68;
      4'd3:    c = 7'h69;
      4'd4:    c = 7'h72;
      4'd5:    c = 7'h20;
      4'd6:    c = 7'h4D;
      4'd7:    c = 7'h61;
      4'd8:    c = 7'h68;
      4'd9:    c = 7'h61;
      4'd10:   c = 7'h6A;
      4'd11:   c = 7'h61;
      4'd12:   c = 7'h6E;
      4'd13:   c = 7'h20;
      default: c = 7'h20;
    endcase
    return c;
  endfunction

  logic [3:0]  pos_n;
  logic [0:13] q_n;
  logic        match_n;
  logic        err_n;
  logic [7:0]  hits_n;

  // Next state: advance on a match, wrap after the final character, and
  // restart (on 'M' only) after a mismatch. Pulses default to 0.
  always_comb begin
    pos_n   = pos;
    match_n = 1'b0;
    err_n   = 1'b0;
    hits_n  = hits;
    q_n     = '0;
    if (valid) begin
      if (ascii == rom(pos)) begin
        if (pos == LAST_IDX) begin
          pos_n   = 4'd0;
          match_n = 1'b1;
          if (hits != 8'hFF) hits_n = hits + 8'd1;
        end else begin
          pos_n = pos + 4'd1;
        end
      end else begin
        err_n = (pos != 4'd0);
        pos_n = (ascii == RESTART_CH) ? 4'd1 : 4'd0;
      end
    end
    // q reflects the last matched index. On the completion cycle it shows the
    // final index even though pos has already wrapped to 0.
    for (int i = 0; i < 14; i++) begin
      q_n[i] = match_n ? (i == 13) : (pos_n == 4'(i + 1));
    end
  end

  // Register all outputs. Reset clears everything asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos   <= 4'd0;
      q     <= '0;
      match <= 1'b0;
      err   <= 1'b0;
      hits  <= 8'd0;
    end else begin
      pos   <= pos_n;
      q     <= q_n;
      match <= match_n;
      err   <= err_n;
      hits  <= hits_n;
    end
  end

endmodule

// File: tb/tb_name_decoder.sv
// Bench for name_decoder: a text-level model of the name, compared against the
// DUT every cycle, plus directed scenarios with hand-computed expectations.
module tb_name_decoder;

  logic        clk;
  logic        reset;
  logic [6:0]  ascii;
  logic        valid;
  logic [0:13] q;
  logic [3:0]  pos;
  logic        match;
  logic        err;
  logic [7:0]  hits;

  int nchk  = 0;
  int nfail = 0;
  int mcount = 0;

  string NAME = "Mihir Mahajan ";

  // model state
  int mpos   = 0;
  int mhits  = 0;
  bit mmatch = 0;
  bit merr   = 0;

  name_decoder dut (
    .clk(clk), .reset(reset), .ascii(ascii), .valid(valid),
    .q(q), .pos(pos), .match(match), .err(err), .hits(hits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: walk through the name text one accepted character at a time.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mpos <= 0; mhits <= 0; mmatch <= 0; merr <= 0;
    end else begin
      mmatch <= 0;
      merr   <= 0;
      if (valid) begin
        if ({1'b0, ascii} == NAME[mpos]) begin
          if (mpos == NAME.len() - 1) begin
            mpos <= 0;
            mmatch <= 1;
            if (mhits < 255) mhits <= mhits + 1;
          end else begin
            mpos <= mpos + 1;
          end
        end else begin
          merr <= (mpos != 0);
          mpos <= ({1'b0, ascii} == NAME[0]) ? 1 : 0;
        end
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    logic [0:13] eq;
    eq = '0;
    if (mmatch) eq[13] = 1'b1;
    else if (mpos > 0) eq[mpos-1] = 1'b1;
    chk("m_pos",   32'(pos),   32'(mpos));
    chk("m_q",     32'(q),     32'(eq));
    chk("m_match", 32'(match), 32'(mmatch));
    chk("m_err",   32'(err),   32'(merr));
    chk("m_hits",  32'(hits),  32'(mhits));
    chk("m_excl",  32'(match & err), 32'd0);
    if (match === 1'b1) mcount++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [6:0] seq [14] = '{7'h4D, 7'h69, 7'h68, 7'h69, 7'h72, 7'h20, 7'h4D,
                           7'h61, 7'h68, 7'h61, 7'h6A, 7'h61, 7'h6E, 7'h20};

  task automatic send(input logic [6:0] c);
    @(negedge clk);
    ascii = c;
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic full(input bit bubbles);
    for (int i = 0; i < 14; i++) begin
      send(seq[i]);
      if (bubbles) idle();
    end
  endtask

  initial begin
    int mc0;
    reset = 1'b1; valid = 1'b0; ascii = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_pos", 32'(pos), 0);
    chk("rst_q", 32'(q), 0);
    chk("rst_hits", 32'(hits), 0);
    chk("rst_match", 32'(match), 0);
    chk("rst_err", 32'(err), 0);

    // full stream, back to back: q walks one-hot 0..13
    for (int i = 0; i < 14; i++) begin
      send(seq[i]);
      chk("walk_pos", 32'(pos), (i == 13) ? 0 : i + 1);
      chk("walk_q", 32'(q), 32'(14'b1 << (13 - i)));
      chk("walk_match", 32'(match), (i == 13) ? 1 : 0);
    end
    chk("s1_hits", 32'(hits), 1);
    idle();
    chk("post_q", 32'(q), 0);
    chk("post_match", 32'(match), 0);

    // same stream with bubbles
    mc0 = mcount;
    full(1'b1);
    chk("bub_hits", 32'(hits), 2);
    chk("bub_pos", 32'(pos), 0);
    chk("bub_mcount", 32'(mcount - mc0), 1);

    // mismatch scenarios
    send(7'h4D); send(7'h69); send(7'h68); send(7'h41);
    chk("mm1_err", 32'(err), 1);
    chk("mm1_pos", 32'(pos), 0);
    chk("mm1_q", 32'(q), 0);
    send(7'h4D); send(7'h69); send(7'h68); send(7'h69);
    send(7'h72); send(7'h20); send(7'h4D); send(7'h4D);
    chk("mm2_err", 32'(err), 1);
    chk("mm2_pos", 32'(pos), 1);
    chk("mm2_q", 32'(q), 32'(14'b1 << 13));
    send(7'h41);
    chk("mm3_err", 32'(err), 1);
    send(7'h6D);
    chk("lc_err", 32'(err), 0);
    chk("lc_pos", 32'(pos), 0);
    chk("lc_q", 32'(q), 0);

    // async reset mid-sequence at pos=9
    for (int i = 0; i < 9; i++) send(seq[i]);
    chk("ar_pre_pos", 32'(pos), 9);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_pos", 32'(pos), 0);
    chk("ar_q", 32'(q), 0);
    chk("ar_hits", 32'(hits), 0);
    valid = 1'b1; ascii = 7'h4D;   // ignored while reset is high
    @(negedge clk);
    valid = 1'b0;
    reset = 1'b0;
    full(1'b0);
    chk("ar_match", 32'(match), 1);
    chk("ar_hits2", 32'(hits), 1);

    // saturation: 256 back-to-back sequences from a fresh reset
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mc0 = mcount;
    for (int n = 0; n < 256; n++) begin
      full(1'b0);
      if (n == 254) chk("sat_255", 32'(hits), 255);
    end
    chk("sat_256", 32'(hits), 255);
    chk("sat_match", 32'(match), 1);
    idle();
    chk("sat_mcount", 32'(mcount - mc0), 256);

    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
